activation_pipe: RTL and testbench
==================================

ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed two's-complement lane width.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fixed-point fraction bits; ONE = 2^FRAC_BITS.
REQ-003 SHALL have parameter LANES, default 8: lanes processed per beat.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: saturation-event counter width.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  input beat accepted when high with in_valid.
REQ-009 SHALL have port in_mode  input  3  activation select: 0 PASS, 1 RELU, 2 HSIGMOID, 3 HTANH, 4 GELU, 5 LEAKY.
REQ-010 SHALL have port in_data  input  LANES*DATA_WIDTH  packed lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port out_valid  output  1  output beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts output beat.
REQ-013 SHALL have port out_data  output  LANES*DATA_WIDTH  activated lanes, same packing as in_data.
REQ-014 SHALL have port sat_count  output  CNT_WIDTH  count of accepted output beats with any clamped lane.
REQ-015 SHALL have port cnt_clr  input  1  synchronous clear of sat_count.
REQ-016 SHALL have port bad_mode  output  1  sticky flag: an unsupported mode was accepted.

Function
REQ-017 SHALL implement a two-stage pipeline (S1: clamp/hard-sigmoid, S2: multiply/select); latency exactly 2 cycles from input acceptance to out_valid when not stalled.
REQ-018 SHALL compute advance = !out_valid || out_ready; in_ready = advance; both stages load only when advance is high; full throughput, one beat per cycle.
REQ-019 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL capture in_mode with its beat; mode may change every beat without affecting beats in flight.
REQ-021 SHALL compute per lane: PASS y=x; RELU y = x>0 ? x : 0.
REQ-022 SHALL compute HSIGMOID y = clamp((x>>>2) + ONE/2, 0, ONE).
REQ-023 SHALL compute HTANH y = clamp(x, -ONE, ONE).
REQ-024 SHALL compute GELU y = (x * HSIGMOID(x)) >>> FRAC_BITS, full-width product, result saturated to DATA_WIDTH signed range.
REQ-025 SHALL compute LEAKY y = x>=0 ? x : x>>>3 (only when ACT_LEAKY_RELU_EN defined).
REQ-026 SHALL treat modes 6, 7 (and 5 when LEAKY compiled out) as PASS and set bad_mode on their acceptance.
REQ-027 SHALL mark a lane clamped when HSIGMOID/HTANH clamp bound is taken or GELU saturates.
REQ-028 SHALL increment sat_count by 1 on each out_valid && out_ready beat with any clamped lane; hold at 2^CNT_WIDTH-1.
REQ-029 SHALL give cnt_clr priority over a simultaneous increment (sat_count becomes 0).
REQ-030 SHALL leave bubbles in place (no collapse) while stalled.

Reset
REQ-031 SHALL on rst_n low, immediately and asynchronously: pipeline valids 0, out_valid 0, out_data 0, sat_count 0, bad_mode 0; in_ready 1 after reset.
REQ-032 SHALL discard beats in flight on reset mid-operation; no output beat produced for them.
REQ-033 SHALL clear bad_mode only by reset.

Configuration
REQ-034 SHALL, with macro ACT_LEAKY_RELU_EN defined, implement mode 5 as LEAKY; without it, mode 5 is PASS and sets bad_mode.

Verification
REQ-035 SHALL cover: FRAC_BITS=8, RELU, lanes {0x0100, 0xFF00, 0, 0x7FFF} -> out {0x0100, 0, 0, 0x7FFF} exactly 2 cycles later.
REQ-036 SHALL cover: HSIGMOID x=0x0000/0x0400/0xFC00 -> 0x0080/0x0100/0x0000; sat_count +1 after acceptance.
REQ-037 SHALL cover: GELU x=0x0100 -> 0x00C0; x=0x7FFF -> 0x7FFF with saturation counted.
REQ-038 SHALL cover: out_ready low 5 cycles with 3 beats issued -> in_ready low, out_data stable, all beats emitted in order after release.
REQ-039 SHALL cover: mode 5 with x=0xFF00 -> 0xFFE0 if ACT_LEAKY_RELU_EN, else 0xFF00 and bad_mode=1.
REQ-040 SHALL cover: rst_n asserted with 2 beats in flight -> out_valid 0 at once, no stale beat after release; cnt_clr coincident with increment -> sat_count 0.

Source files
------------

// File: rtl/activation_pipe.sv
// activation_pipe: two-stage per-lane activation unit (PASS/RELU/HSIGMOID/HTANH/GELU/LEAKY).
// Stage 1 clamps and evaluates the hard sigmoid, stage 2 does the GELU multiply and selects the
// result. Counts output beats carrying any clamped lane; flags unsupported modes stickily.
// Define ACT_LEAKY_RELU_EN to implement mode 5 as LEAKY; otherwise mode 5 acts as PASS and is
// flagged as unsupported.
module activation_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_mode,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]          sat_count,
  input  logic                          cnt_clr,
  output logic                          bad_mode
);

  localparam int DW = DATA_WIDTH;
  localparam int W  = LANES * DATA_WIDTH;

`ifdef ACT_LEAKY_RELU_EN
  localparam bit LeakyEn = 1'b1;
`else
  localparam bit LeakyEn = 1'b0;
`endif

  localparam logic [2:0] ModePass  = 3'd0;
  localparam logic [2:0] ModeRelu  = 3'd1;
  localparam logic [2:0] ModeHsig  = 3'd2;
  localparam logic [2:0] ModeHtanh = 3'd3;
  localparam logic [2:0] ModeGelu  = 3'd4;
  localparam logic [2:0] ModeLeaky = 3'd5;

  // Fixed-point constants held two bits wider than a lane so sums and bounds never overflow.
  localparam logic signed [DW+1:0] OneX =
      {{(DW + 1 - FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [DW+1:0] HalfX   = OneX >>> 1;
  localparam logic signed [DW+1:0] NegOneX = -OneX;

  logic           advance;
  logic           accept;
  logic           mode_bad;
  logic [2:0]     eff_mode;

  // Stage-1 working values and next state
  logic signed [DW-1:0]   x;
  logic signed [DW+1:0]   xe;
  logic signed [DW+1:0]   hsum;
  logic                   hs_lo, hs_hi, th_lo, th_hi;
  logic signed [DW-1:0]   hs;
  logic [W-1:0]           s1_res_d, s1_hs_d;
  logic [LANES-1:0]       s1_clamp_d;

  logic                   s1_valid_q;
  logic                   s1_gelu_q;
  logic [W-1:0]           s1_res_q, s1_hs_q;
  logic [LANES-1:0]       s1_clamp_q;

  // Stage-2 working values and next state
  logic signed [2*DW-1:0] ae, be, prod, sh;
  logic                   ovf;
  logic signed [DW-1:0]   gres;
  logic [W-1:0]           s2_data_d;
  logic [LANES-1:0]       s2_clamp_d;
  logic                   out_clamp_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Unsupported modes fall back to PASS
  always_comb begin
    mode_bad = (in_mode > ModeLeaky) || ((in_mode == ModeLeaky) && !LeakyEn);
    eff_mode = mode_bad ? ModePass : in_mode;
  end

  // Stage 1: per-lane clamps, hard sigmoid, and final value for every non-GELU mode
  always_comb begin
    s1_res_d   = '0;
    s1_hs_d    = '0;
    s1_clamp_d = '0;
    x     = '0;
    xe    = '0;
    hsum  = '0;
    hs_lo = 1'b0;
    hs_hi = 1'b0;
    th_lo = 1'b0;
    th_hi = 1'b0;
    hs    = '0;
    for (int i = 0; i < LANES; i++) begin
      x     = in_data[i*DW +: DW];
      xe    = {{2{x[DW-1]}}, x};
      hsum  = (xe >>> 2) + HalfX;
      hs_lo = hsum[DW+1];
      hs_hi = hsum > OneX;
      hs    = hs_lo ? '0 : (hs_hi ? OneX[DW-1:0] : hsum[DW-1:0]);
      th_lo = xe < NegOneX;
      th_hi = xe > OneX;
      s1_hs_d[i*DW +: DW] = hs;
      unique case (eff_mode)
        ModeRelu:  s1_res_d[i*DW +: DW] = (!x[DW-1] && (|x)) ? x : '0;
        ModeHsig: begin
          s1_res_d[i*DW +: DW] = hs;
          s1_clamp_d[i]        = hs_lo || hs_hi;
        end
        ModeHtanh: begin
          s1_res_d[i*DW +: DW] = th_hi ? OneX[DW-1:0] : (th_lo ? NegOneX[DW-1:0] : x);
          s1_clamp_d[i]        = th_lo || th_hi;
        end
        ModeGelu: begin
          // Raw x kept for the stage-2 multiply; a clamped sigmoid counts as a clamp
          s1_res_d[i*DW +: DW] = x;
          s1_clamp_d[i]        = hs_lo || hs_hi;
        end
        ModeLeaky: s1_res_d[i*DW +: DW] = x[DW-1] ? (x >>> 3) : x;
        default:   s1_res_d[i*DW +: DW] = x;
      endcase
    end
  end

  // Stage-1 register; moves only when the output side can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_gelu_q  <= 1'b0;
      s1_res_q   <= '0;
      s1_hs_q    <= '0;
      s1_clamp_q <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_gelu_q  <= (eff_mode == ModeGelu);
      s1_res_q   <= s1_res_d;
      s1_hs_q    <= s1_hs_d;
      s1_clamp_q <= s1_clamp_d;
    end
  end

  // Stage 2: GELU product with saturation, otherwise forward the stage-1 result
  always_comb begin
    s2_data_d  = '0;
    s2_clamp_d = '0;
    ae   = '0;
    be   = '0;
    prod = '0;
    sh   = '0;
    ovf  = 1'b0;
    gres = '0;
    for (int i = 0; i < LANES; i++) begin
      ae   = {{DW{s1_res_q[i*DW+DW-1]}}, s1_res_q[i*DW +: DW]};
      be   = {{DW{s1_hs_q[i*DW+DW-1]}}, s1_hs_q[i*DW +: DW]};
      prod = ae * be;
      sh   = prod >>> FRAC_BITS;
      ovf  = !((&sh[2*DW-1:DW-1]) || !(|sh[2*DW-1:DW-1]));
      gres = ovf ? (sh[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                 : sh[DW-1:0];
      if (s1_gelu_q) begin
        s2_data_d[i*DW +: DW] = gres;
        s2_clamp_d[i]         = s1_clamp_q[i] || ovf;
      end else begin
        s2_data_d[i*DW +: DW] = s1_res_q[i*DW +: DW];
        s2_clamp_d[i]         = s1_clamp_q[i];
      end
    end
  end

  // Output register; holds while the downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_clamp_q <= 1'b0;
    end else if (advance) begin
      out_valid   <= s1_valid_q;
      out_data    <= s2_data_d;
      out_clamp_q <= |s2_clamp_d;
    end
  end

  // Saturating count of delivered beats with a clamped lane; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (cnt_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_clamp_q && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  // Sticky unsupported-mode flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_mode <= 1'b0;
    end else if (accept && mode_bad) begin
      bad_mode <= 1'b1;
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed and randomized checks of activation_pipe against a
// behavioural per-lane model and an in-order expected-beat queue.
module tb_activation_pipe;

  localparam int DW = 16;
  localparam int F  = 8;
  localparam int L  = 8;
  localparam int CW = 4;
  localparam int W  = L * DW;
  localparam int SAT_MAX = (1 << CW) - 1;

`ifdef ACT_LEAKY_RELU_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_mode = '0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [CW-1:0] sat_count;
  logic          cnt_clr = 1'b0;
  logic          bad_mode;

  activation_pipe #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (F),
    .LANES     (L),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sat_count(sat_count),
    .cnt_clr  (cnt_clr),
    .bad_mode (bad_mode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] data;
    bit           clamp;
  } exp_t;

  exp_t q[$];
  int   m_sat = 0;
  bit   m_bad = 1'b0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int hsig(input int x, output bit c);
    int one = 1 << F;
    int t = (x >>> 2) + one / 2;
    c = 1'b0;
    if (t < 0) begin t = 0; c = 1'b1; end
    else if (t > one) begin t = one; c = 1'b1; end
    return t;
  endfunction

  // Per-lane activation from the arithmetic definitions
  function automatic int lane_act(input int mode, input int x, output bit c);
    int one  = 1 << F;
    int smax = (1 << (DW - 1)) - 1;
    int smin = -(1 << (DW - 1));
    int m = mode;
    int y, h, p;
    bit hc;
    c = 1'b0;
    if (m > 5 || (m == 5 && !LEAKY)) m = 0;
    case (m)
      1: y = (x > 0) ? x : 0;
      2: y = hsig(x, c);
      3: begin
        if (x > one) begin y = one; c = 1'b1; end
        else if (x < -one) begin y = -one; c = 1'b1; end
        else y = x;
      end
      4: begin
        h = hsig(x, hc);
        p = (x * h) >>> F;
        if (p > smax) begin p = smax; c = 1'b1; end
        else if (p < smin) begin p = smin; c = 1'b1; end
        c = c | hc;
        y = p;
      end
      5: y = (x >= 0) ? x : (x >>> 3);
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic exp_t beat_model(input int mode, input logic [W-1:0] d);
    exp_t e;
    logic [DW-1:0] lv;
    int y;
    bit c;
    e.data  = '0;
    e.clamp = 1'b0;
    for (int i = 0; i < L; i++) begin
      lv = d[i*DW +: DW];
      y  = lane_act(mode, int'($signed(lv)), c);
      e.data[i*DW +: DW] = y[DW-1:0];
      e.clamp = e.clamp | c;
    end
    return e;
  endfunction

  function automatic longint lane(input int i);
    return longint'(out_data[i*DW +: DW]);
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    m_sat = 0;
    m_bad = 1'b0;
  end

  // Compare away from the clock edge, then advance the model for the coming edge
  always @(negedge clk) begin
    bit   c;
    exp_t e;
    if (chk_en) begin
      check("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
      check("sat_count", longint'(sat_count), longint'(m_sat));
      check("bad_mode", longint'(bad_mode), longint'(m_bad));
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_beat: got out_data=%0h want no beat at %0t", out_data, $time);
        end else if (out_data !== q[0].data) begin
          bad++;
          $display("FAIL out_data: got=%0h want=%0h at %0t", out_data, q[0].data, $time);
        end
      end
      if (rst_n) begin
        c = 1'b0;
        if (out_valid && out_ready && q.size() != 0) begin
          c = q[0].clamp;
          void'(q.pop_front());
        end
        if (cnt_clr) m_sat = 0;
        else if (out_valid && out_ready && c && m_sat < SAT_MAX) m_sat++;
        if (in_valid && in_ready) begin
          e = beat_model(int'(in_mode), in_data);
          q.push_back(e);
          if (in_mode > 3'd5 || (in_mode == 3'd5 && !LEAKY)) m_bad = 1'b1;
        end
      end
    end
  end

  // Present one beat and return one cycle after it is accepted
  task automatic send(input logic [2:0] mode, input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain", longint'(q.size()), 0);
  endtask

  logic [DW-1:0] picks [8] = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFF00,
                               16'h0400, 16'hFC00, 16'h0000, 16'h0080};

  initial begin
    logic [W-1:0] d;
    bit c;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_sat", longint'(sat_count), 0);
    check("rst_out_data", longint'(out_data[63:0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model with hand-computed values
    check("pin_relu", longint'(lane_act(1, -256, c)), 0);
    check("pin_hsig", longint'(lane_act(2, 'h400, c)), 'h100);
    check("pin_hsig_c", longint'(c), 1);
    check("pin_gelu", longint'(lane_act(4, 'h100, c)), 'hC0);
    check("pin_htanh", longint'(lane_act(3, -512, c)), -256);
    check("pin_leaky", longint'(lane_act(5, -256, c)), LEAKY ? -32 : -256);

    // RELU, two-cycle latency
    d = '0;
    d[15:0] = 16'h0100; d[31:16] = 16'hFF00; d[47:32] = 16'h0000; d[63:48] = 16'h7FFF;
    send(3'd1, d);
    check("relu_lat1", longint'(out_valid), 0);
    @(posedge clk); #1;
    check("relu_lat2", longint'(out_valid), 1);
    check("relu_l0", lane(0), 'h0100);
    check("relu_l1", lane(1), 'h0000);
    check("relu_l3", lane(3), 'h7FFF);

    // HSIGMOID with clamps
    d = '0;
    d[15:0] = 16'h0000; d[31:16] = 16'h0400; d[47:32] = 16'hFC00;
    send(3'd2, d);
    @(posedge clk); #1;
    check("hsig_l0", lane(0), 'h0080);
    check("hsig_l1", lane(1), 'h0100);
    check("hsig_l2", lane(2), 'h0000);
    @(posedge clk); #1;
    check("hsig_sat", longint'(sat_count), 1);

    // GELU
    d = '0;
    d[15:0] = 16'h0100; d[31:16] = 16'h7FFF;
    send(3'd4, d);
    @(posedge clk); #1;
    check("gelu_l0", lane(0), 'h00C0);
    check("gelu_l1", lane(1), 'h7FFF);
    @(posedge clk); #1;
    check("gelu_sat", longint'(sat_count), 2);

    // Clear coincident with an increment
    d = '0;
    d[15:0] = 16'h0400;
    send(3'd2, d);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_prio", longint'(sat_count), 0);

    // Stall: three beats issued while downstream is blocked
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd0; in_data = {L{16'h1111}};
    @(posedge clk); #1;
    in_data = {L{16'h2222}};
    @(posedge clk); #1;
    in_data = {L{16'h3333}};
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_out_l0", lane(0), 'h1111);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Mode 5
    d = '0;
    d[15:0] = 16'hFF00;
    send(3'd5, d);
    check("m5_bad", longint'(bad_mode), LEAKY ? 0 : 1);
    @(posedge clk); #1;
    check("m5_l0", lane(0), LEAKY ? 'hFFE0 : 'hFF00);
    drain();

    // Reset with two beats in flight
    in_valid = 1'b1; in_mode = 3'd0; in_data = {L{16'h4444}};
    @(posedge clk); #1;
    in_data = {L{16'h5555}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", longint'(out_valid), 0);
    check("rst_mid_bad", longint'(bad_mode), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rst_no_stale", longint'(out_valid), 0);
      @(posedge clk); #1;
    end

    // Counter holds at its maximum
    d = '0;
    d[15:0] = 16'h0400;
    for (int i = 0; i < SAT_MAX + 3; i++) send(3'd2, d);
    drain();
    @(posedge clk); #1;
    check("sat_hold", longint'(sat_count), SAT_MAX);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 3'($urandom_range(0, 7));
      for (int i = 0; i < L; i++) begin
        if ($urandom_range(0, 3) == 0) in_data[i*DW +: DW] = picks[$urandom_range(0, 7)];
        else in_data[i*DW +: DW] = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
